pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the datapath's 32-bit combinational adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained segments, one segment per register stage, so long adds close timing at high clock rates.
- Carries a valid/ready handshake with full-pipeline stall.
- Produces sum, carry, signed overflow and zero flags for the execute stage and for future multi-cycle units (MAC, divider).

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and segment count; 1..WIDTH; segment width SEG = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow
- zero  out  1  y == 0

Behaviour:
- Operand conditioning at input:
  - b_eff = sub ? ~b : b
  - c_eff = sub ? ~cin : cin
  - Result: add gives a+b+cin; sub gives a-b-cin, mod 2^WIDTH.
- Stage k (0..STAGES-1) adds segment k of a and b_eff plus the carry registered from stage k-1 (stage 0 uses c_eff).
- Each stage registers its sum segment, its carry, the still-pending upper operand segments, and the lower segments already computed (skew/deskew registers).
- Handshake:
  - Global enable en = ~out_valid | out_ready; in_ready = en (combinational).
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - While en = 0 every stage holds, including valid bits. No data is lost or duplicated.
  - Bubbles (valid = 0) advance when en = 1. Back-to-back issue gives 1 result/cycle.
- Latency: exactly STAGES cycles from accepted input to out_valid when unstalled. STAGES = 1 gives a single registered add.
- Flags (registered with y, aligned to out_valid):
  - cout = final stage carry.
  - ovf = (a[MSB] == b_eff[MSB]) & (y[MSB] != a[MSB]); a[MSB] and b_eff[MSB] are carried down the pipe.
  - zero = ~|y.
- Outputs y, cout, ovf and zero are only meaningful when out_valid = 1, but hold their last value otherwise. Internal data registers update only on en.
- Reset:
  - All valid bits cleared; y, cout, ovf, zero and all internal data registers cleared to 0.
  - Reset mid-operation discards all in-flight operations; out_valid = 0 the cycle after reset asserts.
  - in_ready = 1 during and after reset, since out_valid = 0.
- Simultaneous events: input accept and output drain in the same cycle are legal. Occupancy is unchanged and the pipe shifts.
- Wrap-around: 0xFFFFFFFF + 1 gives y = 0, cout = 1, zero = 1, ovf = 0.
- Elaboration check: WIDTH % STAGES != 0 or STAGES < 1 is a fatal error.

Decomposition:
- Shared package (datapath constants):
  - ALU_OP_ADD = 1'b0, ALU_OP_SUB = 1'b1
  - default XLEN = 32
- Sub-module adder_slice (combinational, parameter SEG): inputs a, b (SEG bits) and ci; outputs s (SEG bits) and co.
- pipe_adder instantiates STAGES adder_slice instances via generate and owns all registers and handshake logic.

Test Plan (WIDTH = 32, STAGES = 4):
- Basic add: reset, then a = 0x0000_0005, b = 0x0000_0003, cin = 0, sub = 0, out_ready = 1 → out_valid exactly 4 cycles later; y = 0x0000_0008, cout = 0, ovf = 0, zero = 0.
- Cross-segment carry and wrap: a = 0xFFFF_FFFF, b = 0x0000_0001 → y = 0, cout = 1, zero = 1, ovf = 0.
- Signed overflow and subtract:
  - a = 0x7FFF_FFFF + b = 1 → y = 0x8000_0000, ovf = 1.
  - sub: a = 5, b = 7, cin = 0 → y = 0xFFFF_FFFE, cout = 0, ovf = 0.
  - sub: a = 0x8000_0000, b = 1 → ovf = 1.
- Stall and throughput:
  - Stream 8 back-to-back ops (a = i, b = 100) with out_ready = 1 → 8 consecutive results 100..107.
  - Repeat with out_ready held low for 3 cycles mid-stream → in_ready = 0 during the stall; all 8 results still arrive, in order, no duplicates.
- Bubbles: issue ops on alternate cycles → out_valid toggles with the same pattern, 4 cycles delayed.
- Reset mid-flight: 3 ops in the pipe, assert reset 1 cycle → out_valid = 0, y = 0 next cycle; no stale result ever emerges; a new op after reset completes correctly in 4 cycles.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared datapath constants for the pipelined adder
// Purpose: opcode encodings and default datapath width shared by the adder,
//          its interface and its bench.
// Ports:   none (package).
package pipe_adder_pkg;

    localparam int   XLEN       = 32;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
// Purpose: groups the operand-in and result-out valid/ready channels.
// Ports:   in_valid/in_ready/a/b/cin/sub   operand channel (master -> slave)
//          out_valid/out_ready/y/cout/ovf/zero  result channel (slave -> master)
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf, zero
    );

endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - one combinational carry-chained adder segment
// Purpose: SEG-bit add with carry in/out; one instance per pipeline stage.
// Ports:   a, b  segment operands
//          ci    carry into the segment
//          s     segment sum
//          co    carry out of the segment MSB
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit add/subtract with valid/ready stall
// Purpose: splits the add into STAGES segments, one per register stage, and
//          returns sum plus carry, signed-overflow and zero flags.
// Ports:   clk    rising-edge clock
//          reset  synchronous active-high reset
//          bus    pipe_adder_if slave: operand channel in, result channel out
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         reset,
    pipe_adder_if.slave  bus
);

    // Guarded so a bad configuration reaches the fatal check below instead
    // of dividing by zero first.
    localparam int STG_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG      = WIDTH / STG_SAFE;

    if ((STAGES < 1) || ((WIDTH % STG_SAFE) != 0)) begin : g_bad_cfg
        $fatal(1, "pipe_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtract is a + ~b + ~cin, so cin acts as a borrow-in on sub.
    assign b_eff = (bus.sub == ALU_OP_SUB) ? ~bus.b   : bus.b;
    assign c_eff = (bus.sub == ALU_OP_SUB) ? ~bus.cin : bus.cin;

    // Whole pipe advances together; it only freezes when a finished result
    // is waiting for a consumer that is not ready.
    assign en           = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W = (k + 1) * SEG;

        logic [SEG-1:0]  sa;
        logic [SEG-1:0]  sb;
        logic [SEG-1:0]  ss;
        logic            sci;
        logic            sco;
        logic            vin;
        logic [LO_W-1:0] lo_d;
        logic            v_q;
        logic            c_q;
        logic [LO_W-1:0] lo_q;

        if (k == 0) begin : g_first
            assign sa   = bus.a[SEG-1:0];
            assign sb   = b_eff[SEG-1:0];
            assign sci  = c_eff;
            assign vin  = bus.in_valid;
            assign lo_d = ss;
        end else begin : g_next
            // Pending operands are stored already shifted, so the segment
            // for this stage is always the low SEG bits of the previous one.
            assign sa   = g_stage[k-1].g_hi.a_q[SEG-1:0];
            assign sb   = g_stage[k-1].g_hi.b_q[SEG-1:0];
            assign sci  = g_stage[k-1].c_q;
            assign vin  = g_stage[k-1].v_q;
            assign lo_d = {ss, g_stage[k-1].lo_q};
        end

        adder_slice #(
            .SEG (SEG)
        ) u_slice (
            .a  (sa),
            .b  (sb),
            .ci (sci),
            .s  (ss),
            .co (sco)
        );

        // Data only moves with a valid operation, so outputs hold their
        // last result while bubbles pass through.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                lo_q <= '0;
            end else if (en) begin
                v_q <= vin;
                if (vin) begin
                    c_q  <= sco;
                    lo_q <= lo_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_hi
            localparam int HI_W = WIDTH - LO_W;

            logic [HI_W-1:0] a_d;
            logic [HI_W-1:0] b_d;
            logic [HI_W-1:0] a_q;
            logic [HI_W-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = bus.a[WIDTH-1:SEG];
                assign b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_src
                assign a_d = g_stage[k-1].g_hi.a_q[HI_W+SEG-1:SEG];
                assign b_d = g_stage[k-1].g_hi.b_q[HI_W+SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en && vin) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic ovf_q;
            logic zero_q;

            // The top operand segment arrives here intact, so its MSBs are
            // the carried-down a[MSB] and b_eff[MSB] used for overflow.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en && vin) begin
                    ovf_q  <= (sa[SEG-1] == sb[SEG-1]) && (ss[SEG-1] != sa[SEG-1]);
                    zero_q <= ~|lo_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.y         = g_stage[STAGES-1].lo_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
    assign bus.zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule
